// File: rtl/fifo_uart_pkg.sv
// Shared types and constants for the capture-FIFO to UART drain path.
// Header byte feature is selected by the FIFO_UART_HEADER_EN macro.
package fifo_uart_pkg;

    localparam int WORD_W = 14;
    localparam logic [7:0] HDR_BYTE_DEF = 8'hA5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_LATCH,
        S_HDR,
        S_B0,
        S_B1
    } state_e;

    // {byte0, byte1}: MSB of each byte tags the high or low half
    function automatic logic [15:0] split_word(input logic [WORD_W-1:0] d);
        return {1'b1, d[13:7], 1'b0, d[6:0]};
    endfunction

endpackage

// File: rtl/uart_byte_tx.sv
// 8N1 byte serialiser: start bit, 8 data bits LSB first, one stop bit.
// Owns the baud and bit counters; done pulses in the last stop-bit cycle.
module uart_byte_tx #(
    parameter int BAUD_DIV = 434
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       start_i,
    input  logic [7:0] data_i,
    output logic       tx_o,
    output logic       done_o
);

    localparam logic [15:0] LAST = 16'(BAUD_DIV - 1);

    logic        active_q;
    logic [15:0] baud_q;
    logic [3:0]  bit_q;
    logic [8:0]  frame_q;
    logic        tx_q;
    logic        bit_end;
    logic        last_bit;

    assign bit_end  = active_q && (baud_q == LAST);
    assign last_bit = bit_end && (bit_q == 4'd9);
    assign done_o   = last_bit;
    assign tx_o     = tx_q;

    // Accept a new byte when idle or in the final stop cycle so bytes chain gaplessly
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            active_q <= 1'b0;
            baud_q   <= '0;
            bit_q    <= '0;
            frame_q  <= '1;
            tx_q     <= 1'b1;
        end else if (start_i && (!active_q || last_bit)) begin
            active_q <= 1'b1;
            baud_q   <= '0;
            bit_q    <= '0;
            frame_q  <= {1'b1, data_i};
            tx_q     <= 1'b0;
        end else if (bit_end) begin
            baud_q <= '0;
            if (last_bit) begin
                active_q <= 1'b0;
                tx_q     <= 1'b1;
            end else begin
                bit_q   <= bit_q + 4'd1;
                tx_q    <= frame_q[0];
                frame_q <= {1'b1, frame_q[8:1]};
            end
        end else if (active_q) begin
            baud_q <= baud_q + 16'd1;
        end
    end

endmodule

// File: rtl/fifo_uart_tx.sv
// Drains 14-bit capture words from a FIFO and sends each as two 8N1 bytes.
// Define FIFO_UART_HEADER_EN to prefix every 4-word group with HDR_BYTE.
module fifo_uart_tx
    import fifo_uart_pkg::*;
#(
    parameter int         BAUD_DIV = 434,
    parameter logic [7:0] HDR_BYTE = HDR_BYTE_DEF
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              fifo_empty,
    input  logic [WORD_W-1:0] fifo_q,
    output logic              fifo_rdreq,
    output logic              uart_tx,
    output logic              busy,
    output logic              word_done
);

    state_e            state_q;
    logic [WORD_W-1:0] word_q;
    logic [1:0]        grp_q;
    logic              rdreq_q;
    logic              busy_q;
    logic              wdone_q;
    logic              send_hdr;
    logic              tx_start;
    logic              tx_done;
    logic [7:0]        tx_data;
    logic [15:0]       pair;

`ifdef FIFO_UART_HEADER_EN
    assign send_hdr = (grp_q == 2'd0);
`else
    assign send_hdr = 1'b0;
`endif

    // In LATCH the word is still on fifo_q, so byte0 can start immediately
    assign pair = split_word((state_q == S_LATCH) ? fifo_q : word_q);

    // Kick the serialiser on entry to a byte state, chained on the previous done
    always_comb begin
        tx_start = 1'b0;
        tx_data  = HDR_BYTE;
        case (state_q)
            S_LATCH: begin
                tx_start = 1'b1;
                if (!send_hdr) tx_data = pair[15:8];
            end
`ifdef FIFO_UART_HEADER_EN
            S_HDR: begin
                tx_start = tx_done;
                tx_data  = pair[15:8];
            end
`endif
            S_B0: begin
                tx_start = tx_done;
                tx_data  = pair[7:0];
            end
            default: ;
        endcase
    end

    // Word sequencer with registered read request, busy and word_done
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= S_IDLE;
            word_q  <= '0;
            grp_q   <= '0;
            rdreq_q <= 1'b0;
            busy_q  <= 1'b0;
            wdone_q <= 1'b0;
        end else begin
            rdreq_q <= 1'b0;
            wdone_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (!fifo_empty) begin
                        state_q <= S_RD;
                        rdreq_q <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end
                S_RD: state_q <= S_LATCH;
                S_LATCH: begin
                    word_q  <= fifo_q;
                    state_q <= send_hdr ? S_HDR : S_B0;
                end
`ifdef FIFO_UART_HEADER_EN
                S_HDR: if (tx_done) state_q <= S_B0;
`endif
                S_B0: if (tx_done) state_q <= S_B1;
                S_B1: begin
                    if (tx_done) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                        wdone_q <= 1'b1;
                        grp_q   <= grp_q + 2'd1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign fifo_rdreq = rdreq_q;
    assign busy       = busy_q;
    assign word_done  = wdone_q;

    uart_byte_tx #(
        .BAUD_DIV(BAUD_DIV)
    ) u_byte (
        .clk_i  (Clk),
        .rst_ni (Rst_n),
        .start_i(tx_start),
        .data_i (tx_data),
        .tx_o   (uart_tx),
        .done_o (tx_done)
    );

endmodule
